// File: rtl/pipe_pkg.sv
// Shared constants for the pipeline inter-stage registers: NOP encoding,
// the "no destination" register address and the per-stage Tnew values.
package pipe_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam logic [4:0]  REG_ZERO  = 5'd0;

  localparam int unsigned TNEW_W_DEFAULT = 2;

  // Cycles until a result becomes available, counted from the ID stage.
  localparam int unsigned TNEW_ALU  = 1;
  localparam int unsigned TNEW_LOAD = 2;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter for performance debug; holds at all-ones and never wraps.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (inc && (cnt != {W{1'b1}})) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Configurable inter-stage register for the 5-stage MIPS pipeline with
// stall/bubble/flush controls, valid gating, optional Tnew decrement and event counters.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int unsigned PAYLOAD_W         = 128,
  parameter int unsigned TNEW_W            = TNEW_W_DEFAULT,
  parameter bit          TNEW_DEC          = 1'b1,
  parameter bit          KEEP_PC_ON_BUBBLE = 1'b1,
  parameter int unsigned CNT_W             = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 stall,
  input  logic                 bubble,
  input  logic                 flush,
  input  logic                 in_valid,
  input  logic [31:0]          in_instr,
  input  logic [31:0]          in_pc,
  input  logic [4:0]           in_regaddr,
  input  logic [TNEW_W-1:0]    in_tnew,
  input  logic [PAYLOAD_W-1:0] in_payload,
  output logic                 out_valid,
  output logic [31:0]          out_instr,
  output logic [31:0]          out_pc,
  output logic [4:0]           out_regaddr,
  output logic [TNEW_W-1:0]    out_tnew,
  output logic [PAYLOAD_W-1:0] out_payload,
  output logic [CNT_W-1:0]     stall_cnt,
  output logic [CNT_W-1:0]     bubble_cnt
);

  localparam logic [TNEW_W-1:0] TNEW_ONE = 1;

  // Control semantics: there is no handshake. in_valid only marks whether the
  // upstream slot carries a real instruction; priority is reset > flush >
  // bubble > stall > load, and only the action actually taken is counted.
  logic take_bubble;
  logic take_stall;

  assign take_bubble = bubble && !flush;
  assign take_stall  = stall && !bubble && !flush;

  // Invalid slots must never look like a forwarding source or a pending producer.
  logic [31:0]       instr_load;
  logic [4:0]        regaddr_load;
  logic [TNEW_W-1:0] tnew_load;

  always_comb begin
    instr_load   = NOP_INSTR;
    regaddr_load = REG_ZERO;
    tnew_load    = '0;
    if (in_valid) begin
      instr_load   = in_instr;
      regaddr_load = in_regaddr;
      if (TNEW_DEC && (in_tnew != '0)) begin
        tnew_load = in_tnew - TNEW_ONE;
      end else begin
        tnew_load = in_tnew;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      out_valid   <= 1'b0;
      out_instr   <= NOP_INSTR;
      out_pc      <= 32'h0;
      out_regaddr <= REG_ZERO;
      out_tnew    <= '0;
      out_payload <= '0;
    end else if (bubble) begin
      // A bubble may keep the PC so a later exception can still report an EPC.
      out_valid   <= 1'b0;
      out_instr   <= NOP_INSTR;
      out_pc      <= KEEP_PC_ON_BUBBLE ? in_pc : 32'h0;
      out_regaddr <= REG_ZERO;
      out_tnew    <= '0;
      out_payload <= '0;
    end else if (!stall) begin
      out_valid   <= in_valid;
      out_instr   <= instr_load;
      out_pc      <= in_pc;
      out_regaddr <= regaddr_load;
      out_tnew    <= tnew_load;
      out_payload <= in_payload;
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (take_stall),
    .cnt   (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_bubble_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (take_bubble),
    .cnt   (bubble_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: three configurations driven in parallel and
// compared each cycle against a per-instance behavioural model.
module tb_pipe_stage_reg;

  logic         clk;
  logic         reset;
  logic         stall;
  logic         bubble;
  logic         flush;
  logic         in_valid;
  logic [31:0]  in_instr;
  logic [31:0]  in_pc;
  logic [4:0]   in_regaddr;
  logic [1:0]   in_tnew;
  logic [127:0] in_payload;

  // a: defaults; b: TNEW_DEC=0, KEEP_PC_ON_BUBBLE=0; c: CNT_W=4
  logic a_valid, b_valid, c_valid;
  logic [31:0] a_instr, b_instr, c_instr, a_pc, b_pc, c_pc;
  logic [4:0] a_ra, b_ra, c_ra;
  logic [1:0] a_tn, b_tn, c_tn;
  logic [127:0] a_pl, b_pl, c_pl;
  logic [15:0] a_sc, a_bc, b_sc, b_bc;
  logic [3:0] c_sc, c_bc;

  int n_vec;
  int n_err;

  typedef struct {
    logic         v;
    logic [31:0]  instr;
    logic [31:0]  pc;
    logic [4:0]   ra;
    logic [1:0]   tn;
    logic [127:0] pl;
    int unsigned  sc;
    int unsigned  bc;
  } mstate_t;

  mstate_t m_a, m_b, m_c;

  pipe_stage_reg u_a (
    .clk(clk), .reset(reset), .stall(stall), .bubble(bubble), .flush(flush),
    .in_valid(in_valid), .in_instr(in_instr), .in_pc(in_pc), .in_regaddr(in_regaddr),
    .in_tnew(in_tnew), .in_payload(in_payload),
    .out_valid(a_valid), .out_instr(a_instr), .out_pc(a_pc), .out_regaddr(a_ra),
    .out_tnew(a_tn), .out_payload(a_pl), .stall_cnt(a_sc), .bubble_cnt(a_bc)
  );

  pipe_stage_reg #(.TNEW_DEC(1'b0), .KEEP_PC_ON_BUBBLE(1'b0)) u_b (
    .clk(clk), .reset(reset), .stall(stall), .bubble(bubble), .flush(flush),
    .in_valid(in_valid), .in_instr(in_instr), .in_pc(in_pc), .in_regaddr(in_regaddr),
    .in_tnew(in_tnew), .in_payload(in_payload),
    .out_valid(b_valid), .out_instr(b_instr), .out_pc(b_pc), .out_regaddr(b_ra),
    .out_tnew(b_tn), .out_payload(b_pl), .stall_cnt(b_sc), .bubble_cnt(b_bc)
  );

  pipe_stage_reg #(.CNT_W(4)) u_c (
    .clk(clk), .reset(reset), .stall(stall), .bubble(bubble), .flush(flush),
    .in_valid(in_valid), .in_instr(in_instr), .in_pc(in_pc), .in_regaddr(in_regaddr),
    .in_tnew(in_tnew), .in_payload(in_payload),
    .out_valid(c_valid), .out_instr(c_instr), .out_pc(c_pc), .out_regaddr(c_ra),
    .out_tnew(c_tn), .out_payload(c_pl), .stall_cnt(c_sc), .bubble_cnt(c_bc)
  );

  wire [231:0] obs_a = {a_valid, a_instr, a_pc, a_ra, a_tn, a_pl, a_sc, a_bc};
  wire [231:0] obs_b = {b_valid, b_instr, b_pc, b_ra, b_tn, b_pl, b_sc, b_bc};
  wire [231:0] obs_c = {c_valid, c_instr, c_pc, c_ra, c_tn, c_pl, 12'd0, c_sc, 12'd0, c_bc};
  wire [695:0] obs_all = {obs_a, obs_b, obs_c};

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic mstate_t mnext(mstate_t s, bit dec, bit keep, int unsigned cmax);
    mstate_t n;
    n = s;
    if (reset) begin
      n = '{default: '0};
    end else if (flush) begin
      n.v = 0; n.instr = 0; n.pc = 0; n.ra = 0; n.tn = 0; n.pl = 0;
    end else if (bubble) begin
      n.v = 0; n.instr = 0; n.ra = 0; n.tn = 0; n.pl = 0;
      n.pc = keep ? in_pc : 32'h0;
      if (n.bc < cmax) n.bc = n.bc + 1;
    end else if (stall) begin
      if (n.sc < cmax) n.sc = n.sc + 1;
    end else begin
      n.v     = in_valid;
      n.pc    = in_pc;
      n.pl    = in_payload;
      n.instr = in_valid ? in_instr : 32'h0;
      n.ra    = in_valid ? in_regaddr : 5'd0;
      if (!in_valid) n.tn = 0;
      else if (dec && in_tnew != 0) n.tn = in_tnew - 2'd1;
      else n.tn = in_tnew;
    end
    return n;
  endfunction

  function automatic logic [231:0] to_vec(mstate_t m);
    return {m.v, m.instr, m.pc, m.ra, m.tn, m.pl, m.sc[15:0], m.bc[15:0]};
  endfunction

  function automatic logic [695:0] exp_all();
    return {to_vec(m_a), to_vec(m_b), to_vec(m_c)};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    m_a = mnext(m_a, 1'b1, 1'b1, 65535);
    m_b = mnext(m_b, 1'b0, 1'b0, 65535);
    m_c = mnext(m_c, 1'b1, 1'b1, 15);
    #1;
  endtask

  task automatic drive(logic v, logic [31:0] instr, logic [31:0] pc, logic [4:0] ra, logic [1:0] tn);
    in_valid   = v;
    in_instr   = instr;
    in_pc      = pc;
    in_regaddr = ra;
    in_tnew    = tn;
    in_payload = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic ctrl(logic r, logic s, logic b, logic f);
    reset = r; stall = s; bubble = b; flush = f;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    ctrl(1, 1, 1, 1);
    in_valid = 1'b1; in_instr = '1; in_pc = '1; in_regaddr = '1; in_tnew = '1; in_payload = '1;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_vec++;
      if (obs_all !== 696'd0) begin
        n_err++;
        $display("FAIL reset_zero cycle %0d: got %h required 0", i, obs_all);
      end
    end
    ctrl(0, 0, 0, 0);
    tick();
    n_vec++;
    if (obs_all !== exp_all() || a_tn !== 2'd2 || b_tn !== 2'd3 || a_pc !== 32'hFFFF_FFFF) begin
      n_err++;
      $display("FAIL reset_release: got %h required %h", obs_all, exp_all());
    end
  endtask

  task automatic test_load_dec();
    ctrl(0, 0, 0, 0);
    drive(1, 32'h0109_4020, 32'h3000, 5'd8, 2'd0);
    tick();
    n_vec++;
    if (obs_all !== exp_all() || a_tn !== 2'd0 || a_pc !== 32'h3000 || a_ra !== 5'd8) begin
      n_err++;
      $display("FAIL load_tnew_sat: got tnew=%0d pc=%h ra=%0d full=%h required %h", a_tn, a_pc, a_ra, obs_all, exp_all());
    end
    drive(1, 32'h8D09_0004, 32'h3000, 5'd9, 2'd2);
    tick();
    n_vec++;
    if (obs_all !== exp_all() || b_tn !== 2'd2 || a_tn !== 2'd1) begin
      n_err++;
      $display("FAIL load_tnew_pass: got dec0=%0d dec1=%0d required 2 1", b_tn, a_tn);
    end
  endtask

  task automatic test_stall();
    logic [127:0] held_pl;
    ctrl(0, 0, 0, 0);
    drive(1, 32'h2008_0005, 32'h3004, 5'd8, 2'd2);
    tick();
    held_pl = m_a.pl;
    ctrl(0, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      drive(1, $urandom, 32'h4000 + 4 * i, 5'($urandom_range(1, 31)), 2'($urandom_range(0, 3)));
      tick();
      n_vec++;
      if (obs_all !== exp_all() || a_pc !== 32'h3004 || a_pl !== held_pl) begin
        n_err++;
        $display("FAIL stall_hold cycle %0d: got %h required %h", i, obs_all, exp_all());
      end
    end
    n_vec++;
    if (a_sc !== 16'd3 || c_sc !== 4'd3) begin
      n_err++;
      $display("FAIL stall_cnt: got %0d/%0d required 3", a_sc, c_sc);
    end
  endtask

  task automatic test_bubble_flush();
    ctrl(0, 0, 1, 0);
    drive(1, 32'h2008_0005, 32'h3008, 5'd8, 2'd1);
    tick();
    n_vec++;
    if (obs_all !== exp_all() || a_pc !== 32'h3008 || a_instr !== 32'd0 || a_valid !== 1'b0
        || a_bc !== 16'd1 || b_pc !== 32'd0) begin
      n_err++;
      $display("FAIL bubble: got pc=%h instr=%h valid=%b bcnt=%0d required 3008 0 0 1", a_pc, a_instr, a_valid, a_bc);
    end
    ctrl(0, 0, 1, 1);
    drive(1, 32'h2008_0005, 32'h300C, 5'd8, 2'd1);
    tick();
    n_vec++;
    if (obs_all !== exp_all() || a_pc !== 32'd0 || a_bc !== 16'd1) begin
      n_err++;
      $display("FAIL flush_bubble: got pc=%h bcnt=%0d required 0 1", a_pc, a_bc);
    end
    ctrl(0, 1, 1, 0);
    drive(1, 32'h2008_0005, 32'h3010, 5'd8, 2'd1);
    tick();
    n_vec++;
    if (obs_all !== exp_all() || a_bc !== 16'd2 || a_sc !== 16'd3 || a_pc !== 32'h3010) begin
      n_err++;
      $display("FAIL stall_bubble: got bcnt=%0d scnt=%0d required 2 3", a_bc, a_sc);
    end
    ctrl(0, 1, 0, 1);
    tick();
    n_vec++;
    if (obs_all !== exp_all() || a_sc !== 16'd3 || a_pc !== 32'd0) begin
      n_err++;
      $display("FAIL stall_flush: got scnt=%0d pc=%h required 3 0", a_sc, a_pc);
    end
  endtask

  task automatic test_invalid();
    ctrl(0, 0, 0, 0);
    drive(0, 32'h2008_0005, 32'h3014, 5'd8, 2'd2);
    tick();
    n_vec++;
    if (obs_all !== exp_all() || a_instr !== 32'd0 || a_ra !== 5'd0 || a_valid !== 1'b0
        || a_tn !== 2'd0 || a_pc !== 32'h3014) begin
      n_err++;
      $display("FAIL invalid_gate: got instr=%h ra=%0d valid=%b tnew=%0d required 0 0 0 0", a_instr, a_ra, a_valid, a_tn);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      ctrl($urandom_range(0, 49) == 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 9) == 0, $urandom_range(0, 19) == 0);
      drive($urandom_range(0, 3) != 0, $urandom, $urandom, 5'($urandom), 2'($urandom));
      tick();
      n_vec++;
      if (obs_all !== exp_all()) begin
        n_err++;
        $display("FAIL random cycle %0d: got %h required %h", i, obs_all, exp_all());
      end
    end
  endtask

  task automatic test_saturation();
    ctrl(1, 0, 0, 0);
    tick();
    ctrl(0, 1, 0, 0);
    for (int i = 0; i < 20; i++) begin
      drive(1, $urandom, $urandom, 5'($urandom), 2'($urandom));
      tick();
      n_vec++;
      if (obs_all !== exp_all()) begin
        n_err++;
        $display("FAIL sat_track cycle %0d: got %h required %h", i, obs_all, exp_all());
      end
    end
    n_vec++;
    if (c_sc !== 4'd15 || a_sc !== 16'd20) begin
      n_err++;
      $display("FAIL sat_stop: got %0d/%0d required 15/20", c_sc, a_sc);
    end
    ctrl(1, 1, 0, 0);
    tick();
    n_vec++;
    if (obs_all !== 696'd0) begin
      n_err++;
      $display("FAIL sat_reset: got %h required 0", obs_all);
    end
    ctrl(0, 0, 0, 0);
    drive(1, 32'h0000_0020, 32'h3018, 5'd3, 2'd1);
    tick();
    n_vec++;
    if (obs_all !== exp_all() || a_pc !== 32'h3018 || c_sc !== 4'd0) begin
      n_err++;
      $display("FAIL post_reset_load: got %h required %h", obs_all, exp_all());
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    n_vec = 0;
    n_err = 0;
    m_a = '{default: '0};
    m_b = '{default: '0};
    m_c = '{default: '0};
    ctrl(1, 0, 0, 0);
    drive(0, 32'h0, 32'h0, 5'd0, 2'd0);
    test_reset();
    test_load_dec();
    test_stall();
    test_bubble_flush();
    test_invalid();
    test_random();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised inter-stage register for the 5-stage MIPS pipeline; replaces the fixed per-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB) with one configurable block.
- Carries instr, PC, destination register address, Tnew and a generic payload bus.
- Adds three things the fixed registers lack: separate stall (hold) and bubble (NOP insert) controls, a valid bit, and an optional Tnew decrement at the stage boundary.
- Also keeps saturating stall and bubble event counters for performance debug.

Parameters:
- PAYLOAD_W, 128: width of the generic payload bus (RD1/RD2/EXT/PC8, etc. concatenated by the instantiating stage).
- TNEW_W, 2: width of the Tnew field.
- TNEW_DEC, 1: 1 means the loaded Tnew is in_tnew-1, saturating at 0; 0 means pass-through.
- KEEP_PC_ON_BUBBLE, 1: 1 means a bubble keeps the incoming PC (for later EPC use); 0 means a bubble zeroes the PC.
- CNT_W, 16: width of each performance counter.

Ports:
- clk, in, 1: clock, rising edge.
- reset, in, 1: synchronous, active-high.
- stall, in, 1: hold the current contents.
- bubble, in, 1: load a NOP instead of the input.
- flush, in, 1: clear to NOP, including the PC.
- in_valid, in, 1: upstream slot holds a real instruction.
- in_instr, in, 32: instruction word.
- in_pc, in, 32: instruction PC.
- in_regaddr, in, 5: destination GPR, 0 means none.
- in_tnew, in, TNEW_W: Tnew at the upstream stage.
- in_payload, in, PAYLOAD_W: stage data.
- out_valid, out, 1: registered valid.
- out_instr, out, 32: registered instruction.
- out_pc, out, 32: registered PC.
- out_regaddr, out, 5: registered destination GPR.
- out_tnew, out, TNEW_W: registered Tnew.
- out_payload, out, PAYLOAD_W: registered payload.
- stall_cnt, out, CNT_W: number of cycles with stall applied.
- bubble_cnt, out, CNT_W: number of bubbles inserted.

Behaviour:
- Reset values: all out_* are 0, including out_valid, out_instr (NOP) and out_pc. stall_cnt and bubble_cnt are 0.
- Latency is 1 cycle; every output is registered and there is no combinational path from input to output.
- Priority per rising edge is reset > flush > bubble > stall > load.
- flush:
  - out_valid, out_instr, out_regaddr, out_tnew, out_payload and out_pc all become 0, regardless of KEEP_PC_ON_BUBBLE.
  - The counters are unchanged.
- bubble:
  - out_valid, out_instr, out_regaddr, out_tnew and out_payload become 0.
  - out_pc becomes in_pc if KEEP_PC_ON_BUBBLE=1, else 0.
  - bubble_cnt increments.
- stall:
  - All out_* keep their value.
  - stall_cnt increments.
- load (none of the controls asserted):
  - All fields take the input values.
  - out_tnew = (TNEW_DEC && in_tnew!=0) ? in_tnew-1 : in_tnew.
  - out_valid = in_valid.
- Valid gating: if in_valid=0 on a load, instr, regaddr and tnew are forced to 0. A zero regaddr is never a forwarding source.
- Simultaneous controls:
  - stall with bubble: acts as a bubble. The hazard unit drives stall upstream and bubble here in the same cycle.
  - stall with flush: acts as a flush.
  - In both cases stall_cnt does not increment.
  - Each counter increments only when its own action is the one taken.
- Counters saturate at 2^CNT_W-1 and do not wrap.
- Reset mid-stall: the contents are cleared. stall has no effect on the reset edge or afterwards until it is reasserted.
- The payload is opaque: no arithmetic, loaded or held bit-exact.
- There is no internal FSM beyond the loaded/held/cleared register behaviour; all state is the registers themselves.

Decomposition:
- Shared package (pipe_pkg) holds:
  - NOP_INSTR = 32'h0
  - REG_ZERO = 5'd0
  - the default TNEW_W
  - localparams for the stage Tnew values: TNEW_ALU=1, TNEW_LOAD=2
- One natural sub-module, sat_counter (parameter W, inputs inc and reset, output cnt), instantiated twice for stall_cnt and bubble_cnt.

Test Plan:
- Reset then idle:
  - Stimulus: reset for 2 cycles with all inputs 0xFFFF_FFFF, then release.
  - Required: all outputs 0 during reset. The next edge loads the inputs, with out_tnew=2 when in_tnew=3 and TNEW_DEC=1.
- Load with decrement:
  - Stimulus: in_tnew=0, in_pc=0x3000, in_regaddr=8, in_valid=1.
  - Required: out_tnew=0 (saturated), out_pc=0x3000, out_regaddr=8.
  - Stimulus: TNEW_DEC=0, in_tnew=2.
  - Required: out_tnew=2.
- Stall hold:
  - Stimulus: load PC 0x3004, then stall for 3 cycles with changing inputs.
  - Required: outputs stay at the 0x3004 contents and stall_cnt=3.
- Bubble vs flush:
  - Stimulus: bubble with in_pc=0x3008 (KEEP_PC_ON_BUBBLE=1).
  - Required: out_pc=0x3008, out_instr=0, out_valid=0, bubble_cnt=1.
  - Stimulus: flush+bubble.
  - Required: out_pc=0 and bubble_cnt unchanged.
- Invalid gating:
  - Stimulus: in_valid=0, in_instr=0x2008_0005, in_regaddr=8.
  - Required: out_instr=0, out_regaddr=0, out_valid=0.
- Counter saturation:
  - Stimulus: CNT_W=4, hold stall for 20 cycles.
  - Required: stall_cnt stops at 15. A subsequent reset returns it to 0.
